// File: rtl/avalon_ram_responder.sv
// Avalon-MM slave RAM with programmable wait states, byte lanes and a sticky error flag.
// Optional: define RAM_RANDOM_WAIT_EN for LFSR-driven random wait counts per access.
module avalon_ram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        error_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e        state;
  logic [3:0]    wait_cnt;
  logic [3:0]    target;
  logic          req;
  logic          accept;
  logic          in_range;
  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic [31:0]   mem [DEPTH_WORDS];

  assign req      = read | write;
  assign offset   = address - BASE_ADDR;
  assign in_range = (address >= BASE_ADDR) &&
                    ({32'd0, offset} < (64'(DEPTH_WORDS) * 64'd4));
  assign idx      = offset[AW+1:2];

`ifdef RAM_RANDOM_WAIT_EN
  logic [7:0]  lfsr;
  logic [3:0]  target_q;
  logic [31:0] rnd;
  assign rnd    = 32'(lfsr) % (WAIT_CYCLES + 1);
  // Fresh draw while idle; the drawn value is frozen for the rest of the wait.
  assign target = (state == StIdle) ? rnd[3:0] : target_q;
  logic unused_rnd;
  assign unused_rnd = ^rnd[31:4];
`else
  assign target = 4'(WAIT_CYCLES);
`endif

  // Gated by reset_n so nothing is stalled or accepted while reset is held.
  assign waitrequest = reset_n & req & (wait_cnt != target);
  assign accept      = reset_n & req & (wait_cnt == target);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= StIdle;
      wait_cnt <= 4'd0;
      readdata <= 32'd0;
      error_o  <= 1'b0;
`ifdef RAM_RANDOM_WAIT_EN
      lfsr     <= 8'hA5;
      target_q <= 4'd0;
`endif
    end else begin
      if (accept) begin
        if (!in_range || (read && write)) error_o <= 1'b1;
        if (read && !write) readdata <= in_range ? mem[idx] : 32'd0;
`ifdef RAM_RANDOM_WAIT_EN
        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`endif
      end
      unique case (state)
        StIdle: begin
          if (req && !accept) begin
            state    <= StWait;
            wait_cnt <= 4'd1;
`ifdef RAM_RANDOM_WAIT_EN
            target_q <= target;
`endif
          end
        end
        StWait: begin
          if (!req || accept) begin
            state    <= StIdle;
            wait_cnt <= 4'd0;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: begin
          state    <= StIdle;
          wait_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Memory has no reset; read&write together is a write.
  always_ff @(posedge clk) begin
    if (accept && write && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) mem[idx][8*b +: 8] <= writedata[8*b +: 8];
      end
    end
  end

  logic unused_offset;
  assign unused_offset = ^{offset[31:AW+2], offset[1:0]};

endmodule

// File: tb/tb_avalon_ram_responder.sv
// Directed bench: three responders with WAIT_CYCLES 0, 2 and 3 share clock and reset.
module tb_avalon_ram_responder;

  localparam int NDUT = 3;
  localparam int WC[NDUT] = '{0, 2, 3};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rd    [NDUT];
  logic        wr    [NDUT];
  logic [31:0] ad    [NDUT];
  logic [3:0]  bes   [NDUT];
  logic [31:0] wds   [NDUT];
  logic        wreq  [NDUT];
  logic [31:0] rdata [NDUT];
  logic        err   [NDUT];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  avalon_ram_responder #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset_n(reset_n), .address(ad[0]), .read(rd[0]), .write(wr[0]),
    .byteenable(bes[0]), .writedata(wds[0]), .waitrequest(wreq[0]), .readdata(rdata[0]),
    .error_o(err[0])
  );
  avalon_ram_responder #(.WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset_n(reset_n), .address(ad[1]), .read(rd[1]), .write(wr[1]),
    .byteenable(bes[1]), .writedata(wds[1]), .waitrequest(wreq[1]), .readdata(rdata[1]),
    .error_o(err[1])
  );
  avalon_ram_responder #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset_n(reset_n), .address(ad[2]), .read(rd[2]), .write(wr[2]),
    .byteenable(bes[2]), .writedata(wds[2]), .waitrequest(wreq[2]), .readdata(rdata[2]),
    .error_o(err[2])
  );

  typedef struct {
    int          d;
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    int          ew;
    logic        crd;
    logic [31:0] erd;
    logic        ee;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One full access: waits while stalled, returns #1 after the accepting edge.
  task automatic do_acc(input int i, input logic r, input logic w, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd, output int waits);
    @(negedge clk);
    rd[i] = r; wr[i] = w; ad[i] = a; bes[i] = be; wds[i] = wd;
    waits = 0;
    #1;
    while (wreq[i] && waits < 40) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (waits >= 40) begin
      total++;
      bad++;
      $display("FAIL timeout: waitrequest stuck on dut %0d, got 40+ want <=15", i);
    end
    @(posedge clk);
    #1;
    rd[i] = 1'b0; wr[i] = 1'b0;
  endtask

  initial begin
    int waits;
    for (int i = 0; i < NDUT; i++) begin
      rd[i] = 0; wr[i] = 0; ad[i] = 0; bes[i] = 0; wds[i] = 0;
    end

    //            d  r  w  addr          be    wdata         ew crd erd           ee
    vt.push_back('{0, 0, 1, 32'hBFC00000, 4'hF, 32'hDEADBEEF, 0, 0, 32'h0,        0});
    vt.push_back('{0, 1, 0, 32'hBFC00000, 4'hF, 32'h0,        0, 1, 32'hDEADBEEF, 0});
    vt.push_back('{0, 0, 1, 32'hBFC00004, 4'hF, 32'h11223344, 0, 0, 32'h0,        0});
    vt.push_back('{0, 0, 1, 32'hBFC00004, 4'hC, 32'hAABBCCDD, 0, 0, 32'h0,        0});
    vt.push_back('{0, 1, 0, 32'hBFC00004, 4'h0, 32'h0,        0, 1, 32'hAABB3344, 0});
    vt.push_back('{0, 0, 1, 32'hBFC00008, 4'hF, 32'h55555555, 0, 0, 32'h0,        0});
    vt.push_back('{0, 0, 1, 32'hBFC00008, 4'h0, 32'hFFFFFFFF, 0, 0, 32'h0,        0});
    vt.push_back('{0, 1, 0, 32'hBFC00008, 4'hF, 32'h0,        0, 1, 32'h55555555, 0});
    vt.push_back('{0, 0, 1, 32'hBFC00008, 4'h5, 32'hA1B2C3D4, 0, 0, 32'h0,        0});
    vt.push_back('{0, 1, 0, 32'hBFC00008, 4'hF, 32'h0,        0, 1, 32'h55B255D4, 0});
    vt.push_back('{0, 0, 1, 32'hBFC00FFC, 4'hF, 32'hCAFEF00D, 0, 0, 32'h0,        0});
    vt.push_back('{0, 1, 0, 32'hBFC00FFE, 4'hF, 32'h0,        0, 1, 32'hCAFEF00D, 0});
    vt.push_back('{0, 1, 1, 32'hBFC00000, 4'hF, 32'h0BADF00D, 0, 1, 32'hCAFEF00D, 1});
    vt.push_back('{0, 1, 0, 32'hBFC00000, 4'hF, 32'h0,        0, 1, 32'h0BADF00D, 1});
    vt.push_back('{1, 0, 1, 32'hBFC00020, 4'hF, 32'h13579BDF, 2, 0, 32'h0,        0});
    vt.push_back('{1, 1, 0, 32'hBFC00020, 4'hF, 32'h0,        2, 1, 32'h13579BDF, 0});
    vt.push_back('{1, 1, 0, 32'h00000000, 4'hF, 32'h0,        2, 1, 32'h0,        1});
    vt.push_back('{1, 0, 1, 32'hBFC01020, 4'hF, 32'hFFFFFFFF, 2, 0, 32'h0,        1});
    vt.push_back('{1, 1, 0, 32'hBFC00020, 4'hF, 32'h0,        2, 1, 32'h13579BDF, 1});
    vt.push_back('{1, 1, 0, 32'hBFC01020, 4'hF, 32'h0,        2, 1, 32'h0,        1});
    vt.push_back('{1, 1, 0, 32'hBFC00020, 4'hF, 32'h0,        2, 1, 32'h13579BDF, 1});
    vt.push_back('{1, 1, 0, 32'hBFBFFFFC, 4'hF, 32'h0,        2, 1, 32'h0,        1});

    // Reset state, including waitrequest low while a request is already driven.
    rd[2] = 1'b1;
    #12;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("reset_rdata%0d", i), rdata[i], 32'h0);
      chk($sformatf("reset_err%0d", i), 32'(err[i]), 32'h0);
    end
    chk("reset_wreq_held_req", 32'(wreq[2]), 32'h0);
    rd[2] = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vt[k]) begin
      do_acc(vt[k].d, vt[k].r, vt[k].w, vt[k].a, vt[k].be, vt[k].wd, waits);
`ifdef RAM_RANDOM_WAIT_EN
      chk($sformatf("vec%0d_waits_le", k), 32'(waits <= WC[vt[k].d]), 32'h1);
`else
      chk($sformatf("vec%0d_waits", k), 32'(waits), 32'(vt[k].ew));
`endif
      if (vt[k].crd) chk($sformatf("vec%0d_rdata", k), rdata[vt[k].d], vt[k].erd);
      chk($sformatf("vec%0d_err", k), 32'(err[vt[k].d]), 32'(vt[k].ee));
    end

`ifndef RAM_RANDOM_WAIT_EN
    // Abort a write after one wait cycle, then confirm memory intact and full wait again.
    do_acc(2, 1'b0, 1'b1, 32'hBFC00010, 4'hF, 32'h77777777, waits);
    chk("w3_write_waits", 32'(waits), 32'd3);
    @(negedge clk);
    wr[2] = 1'b1; ad[2] = 32'hBFC00010; bes[2] = 4'hF; wds[2] = 32'h0;
    #1 chk("abort_wreq_c1", 32'(wreq[2]), 32'h1);
    @(negedge clk);
    #1 chk("abort_wreq_c2", 32'(wreq[2]), 32'h1);
    wr[2] = 1'b0;
    #1 chk("abort_wreq_drop", 32'(wreq[2]), 32'h0);
    do_acc(2, 1'b1, 1'b0, 32'hBFC00010, 4'hF, 32'h0, waits);
    chk("after_abort_waits", 32'(waits), 32'd3);
    chk("after_abort_rdata", rdata[2], 32'h77777777);
    chk("after_abort_err", 32'(err[2]), 32'h0);

    // Asynchronous reset in the middle of a wait.
    @(negedge clk);
    rd[2] = 1'b1; ad[2] = 32'hBFC00010;
    @(negedge clk);
    #1 chk("midwait_wreq_before", 32'(wreq[2]), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    chk("midwait_wreq", 32'(wreq[2]), 32'h0);
    chk("midwait_rdata", rdata[2], 32'h0);
    chk("midwait_err1", 32'(err[1]), 32'h0);
    chk("midwait_err0", 32'(err[0]), 32'h0);
    @(negedge clk);
    rd[2] = 1'b0;
    reset_n = 1'b1;
    do_acc(2, 1'b1, 1'b0, 32'hBFC00010, 4'hF, 32'h0, waits);
    chk("post_reset_waits", 32'(waits), 32'd3);
    chk("post_reset_mem", rdata[2], 32'h77777777);
`else
    for (int n = 0; n < 100; n++) begin
      do_acc(2, 1'b1, 1'b0, 32'hBFC00010, 4'hF, 32'h0, waits);
      chk($sformatf("rand_waits%0d", n), 32'(waits <= WC[2]), 32'h1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
